fft_frame_buffer: RTL and testbench
===================================

Name: fft_frame_buffer

Overview:
- Parametrised successor to the 4-word input store that feeds the 16-point FFT core.
- Collects a serial stream of WIDTH-bit samples into a DEPTH-entry frame and presents the completed frame in parallel on one flattened bus with a valid flag.
- Holds the frame until the FFT core acknowledges it.
- Sits between the sample source (ADC/UART deserialiser) and the FFT butterfly stage; replaces ad-hoc address/enable writes with a fill pointer and a ready/valid/ack handshake.

Parameters:
- WIDTH, 16, bits per sample.
- DEPTH, 16, samples per frame; power of two, 2..64.
- ADDR_W, $clog2(DEPTH), fill-pointer width (derived, not overridden).

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_word  input  WIDTH  incoming sample.
- i_valid  input  1  i_word valid this cycle.
- o_ready  output  1  buffer accepts a sample this cycle.
- i_flush  input  1  discard the partially filled frame.
- o_frame  output  DEPTH*WIDTH  published frame; sample k at bits [k*WIDTH +: WIDTH].
- o_frame_valid  output  1  o_frame holds a complete, unacknowledged frame.
- i_frame_ack  input  1  consumer has taken o_frame.
- o_fill_count  output  ADDR_W+1  samples written into the current fill frame, 0..DEPTH.

Behaviour:
- Reset (i_rst_n low at a rising edge): all storage, o_frame, o_frame_valid, o_fill_count and the fill pointer go to 0; state = FILL. o_ready is 0 while i_rst_n is low and 1 from the first cycle after reset is released. Reset mid-fill or mid-hold discards everything.
- Accept: a sample is written when i_valid && o_ready at the edge. It goes to mem[wptr], wptr increments, o_fill_count increments. Writes with o_ready low are dropped without side effects.
- FSM, single-bank mode:
  - FILL: o_ready = 1. On the accepted write at wptr == DEPTH-1, the same edge publishes the frame: o_frame is updated with all DEPTH samples including the last one, o_frame_valid = 1, wptr = 0, o_fill_count = 0, and the state moves to HOLD.
  - Latency: o_frame_valid rises one edge after the last sample is presented.
  - HOLD: o_ready = 0. o_frame is stable. When i_frame_ack is high at an edge: o_frame_valid = 0, state = FILL, and o_ready = 1 the next cycle.
- o_frame is a registered output. It changes only on publish or reset; ack and flush do not clear its contents.
- i_flush: at the edge, wptr = 0 and o_fill_count = 0; already-written fill samples are treated as garbage. It has no effect on o_frame or o_frame_valid.
  - Flush with a simultaneous i_valid: flush wins and the sample is dropped.
  - Flush in HOLD (single-bank): no-op.
- i_frame_ack while o_frame_valid = 0: ignored.
- Wrap-around: wptr wraps from DEPTH-1 to 0 only via publish. o_fill_count never reads DEPTH in single-bank mode.

Optional Feature:
- Macro FFT_FRAME_PINGPONG_EN.
- Defined: two storage banks. Publishing bank A switches filling to bank B immediately, so o_ready stays 1 during publish and back-to-back streaming runs without a bubble.
  - If B completes while A is still valid and no ack is present at that edge: o_fill_count holds at DEPTH and o_ready = 0 (stall state FULL2).
  - In FULL2, the ack edge publishes B to o_frame with o_frame_valid kept at 1. Filling resumes into A with o_ready = 1 the next cycle.
  - If B completes on the same edge as the ack of A: B is published on that edge, with no stall.
  - Flush in FULL2 is ignored.
- Undefined: single bank, FSM exactly as above. The FULL2 state and second bank are not synthesised.

Test Plan:
- Reset then fill: release reset, stream i_word = 0x0100+k for k = 0..15 with i_valid = 1 each cycle. Required: o_frame_valid = 1 one edge after k = 15; o_frame[k] = 0x0100+k; o_ready = 0; o_fill_count = 0.
- Hold/ack: in HOLD, drive i_valid = 1 with 0xDEAD for 5 cycles, then pulse i_frame_ack. Required: o_frame unchanged; 0xDEAD never stored; o_frame_valid = 0 and o_ready = 1 one cycle after the ack.
- Flush: write 7 samples, assert i_flush together with i_valid (0xBEEF), then stream 16 samples 0x0200+k. Required: o_fill_count 7 → 0; published frame = 0x0200+k; 0xBEEF absent.
- Reset mid-fill: write 10 samples, drive i_rst_n low for 1 cycle. Required: o_fill_count = 0, o_frame all 0, o_frame_valid = 0; a following full frame publishes correctly.
- Spurious ack and gaps: pulse i_frame_ack with no frame valid, and stream with i_valid toggling 1/0. Required: no state change on the spurious ack; the frame publishes after 16 accepted samples, i.e. about 32 cycles.
- FFT_FRAME_PINGPONG_EN:
  - Stream 48 samples continuously, acking each frame 3 cycles after its valid. Required: o_ready stays 1 and 3 frames publish in order.
  - Withhold the ack. Required: o_ready drops after sample 32 with o_fill_count = 16.

Source files
------------

// File: rtl/fft_frame_buffer.sv
// Serial-to-parallel frame store feeding the FFT core: fills DEPTH samples, publishes them
// on o_frame and holds until acknowledged. Define FFT_FRAME_PINGPONG_EN for a two-bank build.
module fft_frame_buffer #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [WIDTH-1:0]       i_word,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_flush,
    output logic [DEPTH*WIDTH-1:0] o_frame,
    output logic                   o_frame_valid,
    input  logic                   i_frame_ack,
    output logic [ADDR_W:0]        o_fill_count
);

`ifdef FFT_FRAME_PINGPONG_EN
    localparam int BANKS = 2;
    typedef enum logic [1:0] {ST_FILL, ST_FULL2} state_t;
`else
    localparam int BANKS = 1;
    typedef enum logic [1:0] {ST_FILL, ST_HOLD} state_t;
`endif
    localparam int SLOTS  = BANKS * DEPTH;
    localparam int SLOT_W = $clog2(SLOTS);
    localparam logic [ADDR_W-1:0] WPTR_ONE = 1;
    localparam logic [ADDR_W:0]   FILL_ONE = 1;
    localparam logic [ADDR_W-1:0] WPTR_LAST = ADDR_W'(DEPTH - 1);

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      wptr_q, wptr_d;
    logic [ADDR_W:0]        fill_q, fill_d;
    logic [WIDTH-1:0]       mem_q [SLOTS];
    logic [WIDTH-1:0]       mem_d [SLOTS];
    logic [DEPTH*WIDTH-1:0] frame_q, frame_d;
    logic                   frame_valid_q, frame_valid_d;
    logic [SLOT_W-1:0]      base;
    logic                   accept;
    logic                   last;
    logic                   publish;

`ifdef FFT_FRAME_PINGPONG_EN
    logic bank_q, bank_d;
    assign base = {bank_q, {ADDR_W{1'b0}}};
`else
    assign base = '0;
`endif

    // Handshake: a sample transfers on any rising edge where i_valid && o_ready (and no
    // flush); o_frame_valid stays high until an edge with i_frame_ack high retires it.
    assign o_ready       = i_rst_n && (state_q == ST_FILL);
    assign accept        = o_ready && i_valid && !i_flush;
    assign last          = accept && (wptr_q == WPTR_LAST);
    assign o_frame       = frame_q;
    assign o_frame_valid = frame_valid_q;
    assign o_fill_count  = fill_q;

    always_comb begin
        state_d       = state_q;
        wptr_d        = wptr_q;
        fill_d        = fill_q;
        mem_d         = mem_q;
        frame_d       = frame_q;
        frame_valid_d = frame_valid_q;
        publish       = 1'b0;
`ifdef FFT_FRAME_PINGPONG_EN
        bank_d        = bank_q;
`endif

        if (accept) begin
            mem_d[base + SLOT_W'(wptr_q)] = i_word;
            wptr_d = wptr_q + WPTR_ONE;
            fill_d = fill_q + FILL_ONE;
        end
        if (i_flush && state_q == ST_FILL) begin
            wptr_d = '0;
            fill_d = '0;
        end

        case (state_q)
            ST_FILL: begin
`ifdef FFT_FRAME_PINGPONG_EN
                if (i_frame_ack) frame_valid_d = 1'b0;
                // A completed bank waits in FULL2 only if the previous frame is still
                // held and not being retired on this very edge.
                if (last) begin
                    if (!frame_valid_q || i_frame_ack) publish = 1'b1;
                    else                              state_d = ST_FULL2;
                end
`else
                if (last) begin
                    publish = 1'b1;
                    state_d = ST_HOLD;
                end
`endif
            end
`ifdef FFT_FRAME_PINGPONG_EN
            ST_FULL2: begin
                if (i_frame_ack) begin
                    publish = 1'b1;
                    state_d = ST_FILL;
                end
            end
`else
            ST_HOLD: begin
                if (i_frame_ack) begin
                    frame_valid_d = 1'b0;
                    state_d       = ST_FILL;
                end
            end
`endif
            default: state_d = ST_FILL;
        endcase

        // Publishing reads the post-write view so the final sample lands in the same edge.
        if (publish) begin
            for (int k = 0; k < DEPTH; k++) begin
                frame_d[k*WIDTH +: WIDTH] = mem_d[base + SLOT_W'(k)];
            end
            frame_valid_d = 1'b1;
            wptr_d        = '0;
            fill_d        = '0;
`ifdef FFT_FRAME_PINGPONG_EN
            bank_d        = ~bank_q;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= ST_FILL;
            wptr_q        <= '0;
            fill_q        <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            for (int i = 0; i < SLOTS; i++) mem_q[i] <= '0;
`ifdef FFT_FRAME_PINGPONG_EN
            bank_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            fill_q        <= fill_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            mem_q         <= mem_d;
`ifdef FFT_FRAME_PINGPONG_EN
            bank_q        <= bank_d;
`endif
        end
    end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Scenario tests plus randomized traffic against a queue-based frame model of fft_frame_buffer.
module tb_fft_frame_buffer;
    localparam int WIDTH  = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic                   clk;
    logic                   i_rst_n;
    logic [WIDTH-1:0]       i_word;
    logic                   i_valid;
    logic                   o_ready;
    logic                   i_flush;
    logic [DEPTH*WIDTH-1:0] o_frame;
    logic                   o_frame_valid;
    logic                   i_frame_ack;
    logic [ADDR_W:0]        o_fill_count;

    int checks;
    int errors;

    fft_frame_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_word(i_word), .i_valid(i_valid),
        .o_ready(o_ready), .i_flush(i_flush), .o_frame(o_frame),
        .o_frame_valid(o_frame_valid), .i_frame_ack(i_frame_ack),
        .o_fill_count(o_fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Reference model: accepted samples of the frame being filled, a frame waiting for
    // publication (two-bank build only) and the frame visible to the consumer.
    logic [WIDTH-1:0] m_fill[$];
    logic [WIDTH-1:0] m_pend[$];
    logic [WIDTH-1:0] m_frame[DEPTH];
    bit               m_valid;

    task automatic model_step(input logic v, input logic [WIDTH-1:0] w, input logic f,
                              input logic a);
        if (!i_rst_n) begin
            m_fill.delete();
            m_pend.delete();
            m_valid = 0;
            foreach (m_frame[k]) m_frame[k] = '0;
            return;
        end
`ifdef FFT_FRAME_PINGPONG_EN
        if (m_pend.size() == DEPTH) begin
            if (a) begin
                foreach (m_frame[k]) m_frame[k] = m_pend[k];
                m_pend.delete();
            end
            return;
        end
        if (a) m_valid = 0;
        if (f) m_fill.delete();
        else if (v) begin
            m_fill.push_back(w);
            if (m_fill.size() == DEPTH) begin
                if (m_valid) m_pend = m_fill;
                else begin
                    foreach (m_frame[k]) m_frame[k] = m_fill[k];
                    m_valid = 1;
                end
                m_fill.delete();
            end
        end
`else
        if (m_valid) begin
            if (a) m_valid = 0;
            return;
        end
        if (f) m_fill.delete();
        else if (v) begin
            m_fill.push_back(w);
            if (m_fill.size() == DEPTH) begin
                foreach (m_frame[k]) m_frame[k] = m_fill[k];
                m_valid = 1;
                m_fill.delete();
            end
        end
`endif
    endtask

    function automatic logic m_ready();
`ifdef FFT_FRAME_PINGPONG_EN
        return i_rst_n && (m_pend.size() == 0);
`else
        return i_rst_n && !m_valid;
`endif
    endfunction

    function automatic logic [ADDR_W:0] m_fill_count();
        if (m_pend.size() == DEPTH) return (ADDR_W+1)'(DEPTH);
        return (ADDR_W+1)'(m_fill.size());
    endfunction

    function automatic logic [DEPTH*WIDTH-1:0] m_flat();
        logic [DEPTH*WIDTH-1:0] r;
        for (int k = 0; k < DEPTH; k++) r[k*WIDTH +: WIDTH] = m_frame[k];
        return r;
    endfunction

    function automatic logic [DEPTH*WIDTH-1:0] ramp_frame(input int start);
        logic [DEPTH*WIDTH-1:0] r;
        for (int k = 0; k < DEPTH; k++) r[k*WIDTH +: WIDTH] = WIDTH'(start + k);
        return r;
    endfunction

    // Driver: present inputs, advance the model, clock once, return after the falling edge.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] w, input logic f, input logic a);
        i_valid = v; i_word = w; i_flush = f; i_frame_ack = a;
        model_step(v, w, f, a);
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0; i_flush = 1'b0; i_frame_ack = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        cycle(1'b1, 16'h1234, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b expected 0", o_ready); end
        i_rst_n = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high: got %b expected 1", o_ready); end
        checks++;
        if (o_frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_frame_valid); end
        checks++;
        if (o_fill_count !== '0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", o_fill_count); end
        checks++;
        if (o_frame !== '0) begin errors++; $display("FAIL reset_frame: got %h expected 0", o_frame); end
    endtask

    task automatic test_fill();
        for (int k = 0; k < DEPTH; k++) begin
            cycle(1'b1, WIDTH'(16'h0100 + k), 1'b0, 1'b0);
            if (k == DEPTH - 2) begin
                checks++;
                if (o_frame_valid !== 1'b0 || o_fill_count !== 5'd15) begin
                    errors++;
                    $display("FAIL fill_before_last: valid %b fill %0d expected 0 and 15", o_frame_valid, o_fill_count);
                end
            end
        end
        checks++;
        if (o_frame_valid !== 1'b1) begin errors++; $display("FAIL fill_valid: got %b expected 1", o_frame_valid); end
        checks++;
        if (o_frame !== ramp_frame(16'h0100)) begin
            errors++; $display("FAIL fill_frame: got %h expected %h", o_frame, ramp_frame(16'h0100));
        end
        checks++;
        if (o_fill_count !== '0) begin errors++; $display("FAIL fill_count_after: got %0d expected 0", o_fill_count); end
        checks++;
`ifdef FFT_FRAME_PINGPONG_EN
        if (o_ready !== 1'b1) begin errors++; $display("FAIL fill_ready: got %b expected 1", o_ready); end
`else
        if (o_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b expected 0", o_ready); end
`endif
    endtask

    task automatic test_hold_ack();
        logic [DEPTH*WIDTH-1:0] held;
        held = o_frame;
`ifndef FFT_FRAME_PINGPONG_EN
        for (int n = 0; n < 5; n++) begin
            cycle(1'b1, 16'hDEAD, 1'b0, 1'b0);
            checks++;
            if (o_frame !== held || o_fill_count !== '0 || o_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable: frame %h fill %0d ready %b expected %h 0 0", o_frame, o_fill_count, o_ready, held);
            end
        end
`endif
        cycle(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (o_frame_valid !== 1'b0) begin errors++; $display("FAIL ack_valid: got %b expected 0", o_frame_valid); end
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL ack_ready: got %b expected 1", o_ready); end
        checks++;
        if (o_frame !== held) begin errors++; $display("FAIL ack_frame_kept: got %h expected %h", o_frame, held); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 7; k++) cycle(1'b1, WIDTH'(16'h0300 + k), 1'b0, 1'b0);
        checks++;
        if (o_fill_count !== 5'd7) begin errors++; $display("FAIL flush_pre_count: got %0d expected 7", o_fill_count); end
        cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
        checks++;
        if (o_fill_count !== '0) begin errors++; $display("FAIL flush_count: got %0d expected 0", o_fill_count); end
        for (int k = 0; k < DEPTH; k++) cycle(1'b1, WIDTH'(16'h0200 + k), 1'b0, 1'b0);
        checks++;
        if (o_frame_valid !== 1'b1 || o_frame !== ramp_frame(16'h0200)) begin
            errors++;
            $display("FAIL flush_frame: valid %b frame %h expected 1 %h", o_frame_valid, o_frame, ramp_frame(16'h0200));
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_fill();
        for (int k = 0; k < 10; k++) cycle(1'b1, WIDTH'(16'h0600 + k), 1'b0, 1'b0);
        checks++;
        if (o_fill_count !== 5'd10) begin errors++; $display("FAIL rst_pre_count: got %0d expected 10", o_fill_count); end
        i_rst_n = 1'b0;
        cycle(1'b1, 16'h0666, 1'b0, 1'b0);
        checks++;
        if (o_fill_count !== '0 || o_frame_valid !== 1'b0 || o_frame !== '0 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_fill: fill %0d valid %b ready %b frame %h expected all 0", o_fill_count, o_frame_valid, o_ready, o_frame);
        end
        i_rst_n = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", o_ready); end
        for (int k = 0; k < DEPTH; k++) cycle(1'b1, WIDTH'(16'h0400 + k), 1'b0, 1'b0);
        checks++;
        if (o_frame_valid !== 1'b1 || o_frame !== ramp_frame(16'h0400)) begin
            errors++;
            $display("FAIL rst_refill_frame: valid %b frame %h expected 1 %h", o_frame_valid, o_frame, ramp_frame(16'h0400));
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_spurious_ack_gaps();
        int accepted;
        int cycles;
        for (int k = 0; k < 3; k++) cycle(1'b1, WIDTH'(16'h0700 + k), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (o_fill_count !== 5'd3 || o_frame_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL spurious_ack: fill %0d valid %b ready %b expected 3 0 1", o_fill_count, o_frame_valid, o_ready);
        end
        accepted = 3;
        cycles = 0;
        while (accepted < DEPTH && cycles < 100) begin
            if (cycles % 2 == 0) begin
                cycle(1'b1, WIDTH'(16'h0700 + accepted), 1'b0, 1'b0);
                accepted++;
            end else begin
                cycle(1'b0, 16'h5555, 1'b0, 1'b0);
            end
            cycles++;
        end
        checks++;
        if (cycles !== 25) begin errors++; $display("FAIL gaps_cycles: got %0d expected 25", cycles); end
        checks++;
        if (o_frame_valid !== 1'b1 || o_frame !== ramp_frame(16'h0700)) begin
            errors++;
            $display("FAIL gaps_frame: valid %b frame %h expected 1 %h", o_frame_valid, o_frame, ramp_frame(16'h0700));
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

`ifdef FFT_FRAME_PINGPONG_EN
    task automatic test_pp_stream();
        int  pub;
        int  ack_cd;
        bit  prev_valid;
        pub = 0;
        ack_cd = 0;
        prev_valid = o_frame_valid;
        for (int n = 0; n < 3 * DEPTH; n++) begin
            logic a;
            checks++;
            if (o_ready !== 1'b1) begin errors++; $display("FAIL pp_stream_ready: sample %0d got %b expected 1", n, o_ready); end
            a = (ack_cd == 1);
            if (ack_cd > 0) ack_cd--;
            cycle(1'b1, WIDTH'(16'h0800 + n), 1'b0, a);
            if (o_frame_valid && !prev_valid) begin
                checks++;
                if (o_frame !== ramp_frame(16'h0800 + DEPTH * pub)) begin
                    errors++;
                    $display("FAIL pp_stream_frame%0d: got %h expected %h", pub, o_frame, ramp_frame(16'h0800 + DEPTH * pub));
                end
                pub++;
                ack_cd = 3;
            end
            prev_valid = o_frame_valid;
        end
        checks++;
        if (pub !== 3) begin errors++; $display("FAIL pp_stream_count: got %0d expected 3", pub); end
        cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_pp_stall();
        for (int n = 0; n < 40; n++) begin
            checks++;
            if (o_ready !== (n < 2 * DEPTH)) begin
                errors++; $display("FAIL pp_stall_ready: sample %0d got %b expected %b", n, o_ready, n < 2 * DEPTH);
            end
            cycle(1'b1, WIDTH'(16'h0900 + n), 1'b0, 1'b0);
        end
        checks++;
        if (o_fill_count !== 5'd16 || o_frame_valid !== 1'b1 || o_frame !== ramp_frame(16'h0900)) begin
            errors++;
            $display("FAIL pp_stall_full2: fill %0d valid %b frame %h expected 16 1 %h", o_fill_count, o_frame_valid, o_frame, ramp_frame(16'h0900));
        end
        cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
        checks++;
        if (o_fill_count !== 5'd16) begin errors++; $display("FAIL pp_full2_flush: got %0d expected 16", o_fill_count); end
        cycle(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (o_frame_valid !== 1'b1 || o_ready !== 1'b1 || o_fill_count !== '0 || o_frame !== ramp_frame(16'h0910)) begin
            errors++;
            $display("FAIL pp_full2_ack: valid %b ready %b fill %0d frame %h expected 1 1 0 %h", o_frame_valid, o_ready, o_fill_count, o_frame, ramp_frame(16'h0910));
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (o_frame_valid !== 1'b0) begin errors++; $display("FAIL pp_final_ack: got %b expected 0", o_frame_valid); end
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            logic             v;
            logic             f;
            logic             a;
            logic [WIDTH-1:0] w;
            v = ($urandom_range(0, 9) < 7);
            f = ($urandom_range(0, 39) == 0);
            a = ($urandom_range(0, 4) == 0);
            w = WIDTH'($urandom);
            if ($urandom_range(0, 299) == 0) i_rst_n = 1'b0;
            #1;
            checks++;
            if (o_ready !== m_ready()) begin
                errors++; $display("FAIL rand_ready: cycle %0d got %b expected %b", n, o_ready, m_ready());
            end
            cycle(v, w, f, a);
            i_rst_n = 1'b1;
            checks++;
            if (o_frame_valid !== m_valid) begin
                errors++; $display("FAIL rand_valid: cycle %0d got %b expected %b", n, o_frame_valid, m_valid);
            end
            checks++;
            if (o_fill_count !== m_fill_count()) begin
                errors++; $display("FAIL rand_fill: cycle %0d got %0d expected %0d", n, o_fill_count, m_fill_count());
            end
            checks++;
            if (o_frame !== m_flat()) begin
                errors++; $display("FAIL rand_frame: cycle %0d got %h expected %h", n, o_frame, m_flat());
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        i_rst_n = 1'b0;
        i_word = '0;
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_frame_ack = 1'b0;
        test_reset();
        test_fill();
        test_hold_ack();
        test_flush();
        test_reset_mid_fill();
        test_spurious_ack_gaps();
`ifdef FFT_FRAME_PINGPONG_EN
        test_pp_stream();
        test_pp_stall();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
